// File: rtl/tcb_lite_vip_subordinate_if.sv
// rtl/tcb_lite_vip_subordinate_if.sv - TCB-Lite request/response bundle
interface tcb_lite_vip_subordinate_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  // request channel
  logic            vld;
  logic            rdy;
  logic            wen;
  logic [AW-1:0]   adr;
  logic [DW/8-1:0] ben;
  logic [DW-1:0]   wdt;
  // response channel
  logic [DW-1:0]   rdt;
  logic            err;

  modport master (
    output vld, wen, adr, ben, wdt,
    input  rdy, rdt, err
  );

  modport slave (
    input  vld, wen, adr, ben, wdt,
    output rdy, rdt, err
  );
endinterface

// File: rtl/tcb_lite_vip_subordinate.sv
// rtl/tcb_lite_vip_subordinate.sv - TCB-Lite responder with memory, backpressure and fixed response delay
module tcb_lite_vip_subordinate #(
  parameter int AW   = 8,
  parameter int DW   = 32,
  parameter int SIZE = 64,
  parameter int DLY  = 1,
  parameter int BPR  = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  tcb_lite_vip_subordinate_if.slave tcb
);

  localparam int BW = DW / 8;
  localparam int IW = AW - 2;
  localparam int MW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int CW = (BPR > 1) ? $clog2(BPR) : 1;
  localparam logic [IW:0] SIZE_W = (IW+1)'(SIZE);

  // Elaboration-time parameter sanity
  if (DW != 32) begin : g_chk_dw
    $fatal(1, "tcb_lite_vip_subordinate: DW must be 32");
  end
  if (DLY < 1 || DLY > 4) begin : g_chk_dly
    $fatal(1, "tcb_lite_vip_subordinate: DLY must be in 1..4");
  end
  if (SIZE > 2**(AW-2)) begin : g_chk_size
    $fatal(1, "tcb_lite_vip_subordinate: SIZE exceeds address space");
  end

  typedef enum logic {
    ST_WAIT = 1'b0,
    ST_RDY  = 1'b1
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            rdy_q;
  logic            trn;

  logic [IW-1:0]   idx;
  logic [MW-1:0]   mem_idx;
  logic            adr_err;
  logic [DW-1:0]   rd_word;
  logic [DW-1:0]   s1_rdt_d;
  logic            s1_err_d;

  logic [DW-1:0]   mem_q  [SIZE];
  logic            pvld_q [DLY];
  logic [DW-1:0]   prdt_q [DLY];
  logic            perr_q [DLY];

  // rdy comes straight from a flop, so the manager never sees a path from its own vld
  assign trn     = tcb.vld & rdy_q;
  assign tcb.rdy = rdy_q;

  // Backpressure FSM: BPR counted stall cycles with vld high, then one ready cycle per transfer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_WAIT;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (BPR == 0) begin
            state_q <= ST_RDY;
            rdy_q   <= 1'b1;
          end else if (tcb.vld) begin
            if (int'(cnt_q) == BPR - 1) begin
              state_q <= ST_RDY;
              rdy_q   <= 1'b1;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_RDY: begin
          if (trn && (BPR > 0)) begin
            state_q <= ST_WAIT;
            rdy_q   <= 1'b0;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= ST_WAIT;
          rdy_q   <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Address decode: misaligned or beyond the memory depth is an error
  always_comb begin
    idx      = tcb.adr[AW-1:2];
    mem_idx  = idx[MW-1:0];
    adr_err  = (tcb.adr[1:0] != 2'b00) || ({1'b0, idx} >= SIZE_W);
    rd_word  = '0;
    if (!adr_err) begin
      rd_word = mem_q[mem_idx];
    end
  end

  // First response stage contents; non-read or idle cycles carry zeros
  always_comb begin
    s1_rdt_d = '0;
    s1_err_d = 1'b0;
    if (trn) begin
      s1_err_d = adr_err;
      if (!tcb.wen && !adr_err) begin
        s1_rdt_d = rd_word;
      end
    end
  end

  // Memory write with byte lanes; contents survive reset on purpose
  always_ff @(posedge clk) begin
    if (trn && tcb.wen && !adr_err) begin
      for (int i = 0; i < BW; i++) begin
        if (tcb.ben[i]) begin
          mem_q[mem_idx][8*i +: 8] <= tcb.wdt[8*i +: 8];
        end
      end
    end
  end

  // Response delay line; reset drops anything in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DLY; i++) begin
        pvld_q[i] <= 1'b0;
        prdt_q[i] <= '0;
        perr_q[i] <= 1'b0;
      end
    end else begin
      pvld_q[0] <= trn;
      prdt_q[0] <= s1_rdt_d;
      perr_q[0] <= s1_err_d;
      for (int i = 1; i < DLY; i++) begin
        pvld_q[i] <= pvld_q[i-1];
        prdt_q[i] <= prdt_q[i-1];
        perr_q[i] <= perr_q[i-1];
      end
    end
  end

  assign tcb.rdt = pvld_q[DLY-1] ? prdt_q[DLY-1] : '0;
  assign tcb.err = pvld_q[DLY-1] & perr_q[DLY-1];

endmodule

// File: tb/tb_tcb_lite_vip_subordinate.sv
// tb/tb_tcb_lite_vip_subordinate.sv - scoreboard bench for the TCB-Lite responder
module tb_tcb_lite_vip_subordinate;

  logic        clk;
  logic        rst;
  logic        vld [3];
  logic        wen [3];
  logic [9:0]  adr [3];
  logic [3:0]  ben [3];
  logic [31:0] wdt [3];
  logic        rdy [3];
  logic [31:0] rdt [3];
  logic        err [3];

  logic [32:0] exp_q [3][$];
  int          due_q [3][$];
  int          cyc   = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  // dut 0: BPR=0 DLY=1, dut 1: BPR=2 DLY=3, dut 2: BPR=0 DLY=4
  function automatic int dly_of(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 3 : 4);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int GBPR = (g == 1) ? 2 : 0;
    localparam int GDLY = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    tcb_lite_vip_subordinate_if #(.AW(10), .DW(32)) bus ();
    assign bus.vld = vld[g];
    assign bus.wen = wen[g];
    assign bus.adr = adr[g];
    assign bus.ben = ben[g];
    assign bus.wdt = wdt[g];
    assign rdy[g]  = bus.rdy;
    assign rdt[g]  = bus.rdt;
    assign err[g]  = bus.err;
    tcb_lite_vip_subordinate #(
      .AW(10), .DW(32), .SIZE(64), .DLY(GDLY), .BPR(GBPR)
    ) dut (
      .clk (clk),
      .rst (rst),
      .tcb (bus.slave)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // record when each transfer's response is due
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (rst && vld[g] && rdy[g]) due_q[g].push_back(cyc + dly_of(g));
    end
    cyc = cyc + 1;
  end

  // scoreboard: pop expected at the due cycle, otherwise outputs must be zero
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (due_q[g].size() > 0 && due_q[g][0] == cyc) begin
        void'(due_q[g].pop_front());
        n_cmp++;
        if (exp_q[g].size() == 0) begin
          n_bad++;
          $display("FAIL sb_underflow dut%0d cyc=%0d got rdt=%h err=%b, no expectation queued", g, cyc, rdt[g], err[g]);
        end else begin
          logic [32:0] e;
          e = exp_q[g].pop_front();
          if ({err[g], rdt[g]} !== e) begin
            n_bad++;
            $display("FAIL sb_resp dut%0d cyc=%0d got rdt=%h err=%b, expected rdt=%h err=%b", g, cyc, rdt[g], err[g], e[31:0], e[32]);
          end
        end
      end else begin
        n_cmp++;
        if (rdt[g] !== 32'h0 || err[g] !== 1'b0) begin
          n_bad++;
          $display("FAIL idle_out dut%0d cyc=%0d got rdt=%h err=%b, expected 0/0", g, cyc, rdt[g], err[g]);
        end
      end
    end
  end

  // one request; called at a negedge, returns at the negedge after the transfer edge
  task automatic xfer(input int g, input logic w, input logic [9:0] a, input logic [3:0] b,
                      input logic [31:0] d, input logic [31:0] xr, input logic xe, output int stalls);
    exp_q[g].push_back({xe, xr});
    vld[g] = 1'b1; wen[g] = w; adr[g] = a; ben[g] = b; wdt[g] = d;
    stalls = 0;
    while (rdy[g] !== 1'b1 && stalls < 16) begin
      @(negedge clk);
      stalls++;
    end
    if (stalls >= 16) begin
      n_cmp++; n_bad++;
      $display("FAIL xfer_timeout dut%0d adr=%h got no rdy in %0d cycles, expected rdy", g, a, stalls);
    end
    @(negedge clk);
    vld[g] = 1'b0; wen[g] = 1'b0; adr[g] = '0; ben[g] = '0; wdt[g] = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        n_cmp++;
        if (rdy[g] !== 1'b0) begin
          n_bad++;
          $display("FAIL reset_rdy dut%0d got %b, expected 0", g, rdy[g]);
        end
      end
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (rdy[0] !== 1'b1 || rdy[2] !== 1'b1 || rdy[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL release_rdy got %b%b%b, expected 1,0,1", rdy[0], rdy[1], rdy[2]);
    end
  endtask

  task automatic test_write_read;
    int s;
    xfer(0, 1'b1, 10'h004, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, s);
    n_cmp++;
    if (s !== 0) begin n_bad++; $display("FAIL wr_stall got %0d, expected 0", s); end
    xfer(0, 1'b0, 10'h004, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0, s);
    n_cmp++;
    if (rdt[0] !== 32'hDEADBEEF || err[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL rd_dly1 got rdt=%h err=%b, expected deadbeef/0", rdt[0], err[0]);
    end
    idle(2);
  endtask

  task automatic test_byte_enables;
    int s;
    xfer(0, 1'b1, 10'h008, 4'hF, 32'h11223344, 32'h0, 1'b0, s);
    xfer(0, 1'b1, 10'h008, 4'h5, 32'hAABBCCDD, 32'h0, 1'b0, s);
    xfer(0, 1'b0, 10'h008, 4'h0, 32'h0, 32'h11BB33DD, 1'b0, s);
    n_cmp++;
    if (rdt[0] !== 32'h11BB33DD) begin
      n_bad++;
      $display("FAIL byte_en got %h, expected 11bb33dd", rdt[0]);
    end
    idle(2);
  endtask

  task automatic test_errors;
    int s;
    xfer(0, 1'b1, 10'h000, 4'hF, 32'h12345678, 32'h0, 1'b0, s);
    xfer(0, 1'b0, 10'h102, 4'h0, 32'h0, 32'h0, 1'b1, s);
    n_cmp++;
    if (err[0] !== 1'b1 || rdt[0] !== 32'h0) begin
      n_bad++;
      $display("FAIL rd_err got rdt=%h err=%b, expected 0/1", rdt[0], err[0]);
    end
    xfer(0, 1'b1, 10'h100, 4'hF, 32'hBAD0BAD0, 32'h0, 1'b1, s);
    xfer(0, 1'b0, 10'h100, 4'h0, 32'h0, 32'h0, 1'b1, s);
    xfer(0, 1'b0, 10'h000, 4'h0, 32'h0, 32'h12345678, 1'b0, s);
    n_cmp++;
    if (rdt[0] !== 32'h12345678) begin
      n_bad++;
      $display("FAIL mem0_kept got %h, expected 12345678", rdt[0]);
    end
    xfer(0, 1'b1, 10'h0FC, 4'hF, 32'hA5A5C3C3, 32'h0, 1'b0, s);
    xfer(0, 1'b0, 10'h0FC, 4'h0, 32'h0, 32'hA5A5C3C3, 1'b0, s);
    xfer(0, 1'b1, 10'h0F9, 4'hF, 32'h77777777, 32'h0, 1'b1, s);
    xfer(0, 1'b0, 10'h0FC, 4'h0, 32'h0, 32'hA5A5C3C3, 1'b0, s);
    idle(2);
  endtask

  task automatic test_back_to_back;
    logic [31:0] m [8];
    logic [31:0] d;
    logic [3:0]  b;
    int          s;
    int          tot = 0;
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      m[i] = d;
      xfer(0, 1'b1, 10'(10'h040 + 4*i), 4'hF, d, 32'h0, 1'b0, s);
      tot += s;
    end
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      b = 4'($urandom_range(1, 15));
      for (int l = 0; l < 4; l++) if (b[l]) m[i][8*l +: 8] = d[8*l +: 8];
      xfer(0, 1'b1, 10'(10'h040 + 4*i), b, d, 32'h0, 1'b0, s);
      tot += s;
    end
    for (int i = 0; i < 8; i++) begin
      xfer(0, 1'b0, 10'(10'h040 + 4*i), 4'h0, 32'h0, m[i], 1'b0, s);
      tot += s;
    end
    n_cmp++;
    if (tot !== 0) begin n_bad++; $display("FAIL b2b_stalls got %0d, expected 0", tot); end
    idle(3);
    n_cmp++;
    if (exp_q[0].size() != 0 || due_q[0].size() != 0) begin
      n_bad++;
      $display("FAIL b2b_drain got %0d/%0d pending, expected 0/0", exp_q[0].size(), due_q[0].size());
    end
  endtask

  task automatic test_backpressure;
    int s;
    for (int i = 0; i < 3; i++) begin
      xfer(1, 1'b1, 10'(10'h020 + 4*i), 4'hF, 32'hC0DE0000 + 32'(i), 32'h0, 1'b0, s);
      n_cmp++;
      if (s !== 2) begin n_bad++; $display("FAIL bpr_wr_stall%0d got %0d, expected 2", i, s); end
    end
    for (int i = 0; i < 3; i++) begin
      xfer(1, 1'b0, 10'(10'h020 + 4*i), 4'h0, 32'h0, 32'hC0DE0000 + 32'(i), 1'b0, s);
      n_cmp++;
      if (s !== 2) begin n_bad++; $display("FAIL bpr_rd_stall%0d got %0d, expected 2", i, s); end
      n_cmp++;
      if (rdy[1] !== 1'b0) begin n_bad++; $display("FAIL bpr_rdy_drop got %b, expected 0", rdy[1]); end
    end
    idle(5);
    n_cmp++;
    if (exp_q[1].size() != 0 || due_q[1].size() != 0) begin
      n_bad++;
      $display("FAIL bpr_drain got %0d/%0d pending, expected 0/0", exp_q[1].size(), due_q[1].size());
    end
  endtask

  task automatic test_reset_mid;
    int s;
    int hits = 0;
    xfer(2, 1'b1, 10'h010, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0, s);
    idle(6);
    xfer(2, 1'b0, 10'h010, 4'h0, 32'h0, 32'hCAFEF00D, 1'b0, s);
    @(negedge clk);
    rst = 1'b0;
    for (int g = 0; g < 3; g++) begin
      exp_q[g].delete();
      due_q[g].delete();
    end
    #1;
    n_cmp++;
    if (rdy[2] !== 1'b0) begin n_bad++; $display("FAIL midrst_rdy got %b, expected 0", rdy[2]); end
    repeat (2) begin
      @(negedge clk);
      n_cmp++;
      if (rdy[2] !== 1'b0) begin n_bad++; $display("FAIL midrst_hold_rdy got %b, expected 0", rdy[2]); end
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (rdy[2] !== 1'b0) begin n_bad++; $display("FAIL midrst_release_rdy got %b, expected 0", rdy[2]); end
    @(negedge clk);
    n_cmp++;
    if (rdy[2] !== 1'b1) begin n_bad++; $display("FAIL midrst_after_rdy got %b, expected 1", rdy[2]); end
    for (int k = 0; k < 8; k++) begin
      if (rdt[2] !== 32'h0 || err[2] !== 1'b0) hits++;
      @(negedge clk);
    end
    n_cmp++;
    if (hits !== 0) begin n_bad++; $display("FAIL midrst_leak got %0d responses, expected 0", hits); end
    xfer(2, 1'b0, 10'h010, 4'h0, 32'h0, 32'hCAFEF00D, 1'b0, s);
    idle(6);
    n_cmp++;
    if (exp_q[2].size() != 0 || due_q[2].size() != 0) begin
      n_bad++;
      $display("FAIL midrst_drain got %0d/%0d pending, expected 0/0", exp_q[2].size(), due_q[2].size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    for (int g = 0; g < 3; g++) begin
      vld[g] = 1'b0; wen[g] = 1'b0; adr[g] = '0; ben[g] = '0; wdt[g] = '0;
    end
    test_reset;
    test_write_read;
    test_byte_enables;
    test_errors;
    test_back_to_back;
    test_backpressure;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tcb_lite_vip_subordinate.md
Name: tcb_lite_vip_subordinate

Overview:
- Synthesizable TCB-Lite responder (subordinate/memory model): the far end of the bus from the manager and the passive monitor.
- Accepts requests through a configurable backpressure FSM and stores writes into a word-addressed memory with byte enables.
- Returns read data and error at the fixed response delay DLY.
- Used in testbenches opposite the manager VIP and monitor; small enough to map into FPGA test harnesses.

Parameters:
- AW, 8: byte address width.
- DW, 32: data width; must be 32 (4 byte lanes).
- SIZE, 64: memory depth in words; SIZE <= 2**(AW-2).
- DLY, 1: response delay in cycles after transfer; legal range 1..4.
- BPR, 0: backpressure cycles inserted before each transfer; 0 = always ready.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: asynchronous active-low reset.
- tcb_vld, input, 1: request valid.
- tcb_rdy, output, 1: request ready; transfer trn = tcb_vld & tcb_rdy.
- tcb_wen, input, 1: 1 = write, 0 = read.
- tcb_adr, input, AW: byte address.
- tcb_ben, input, DW/8: byte enables, write only.
- tcb_wdt, input, DW: write data.
- tcb_rdt, output, DW: read data, valid DLY cycles after trn.
- tcb_err, output, 1: error response, valid DLY cycles after trn.

Behaviour:
- Reset (rst=0, async):
  - FSM to WAIT, backpressure counter cnt=0.
  - tcb_rdy=0, tcb_rdt=0, tcb_err=0.
  - Response pipeline valid bits cleared; pending responses are discarded, never emitted.
  - Memory contents are not cleared; simulation initial value is 0.
- Ready FSM (tcb_rdy decoded from registered state, no combinational path from inputs):
  - WAIT: tcb_rdy=0.
    - If BPR==0: next cycle goes to RDY unconditionally.
    - Else if tcb_vld: cnt++; when cnt==BPR-1 and tcb_vld, go to RDY with cnt=0.
    - If tcb_vld is low: cnt holds.
  - RDY: tcb_rdy=1.
    - If trn and BPR>0: go to WAIT with cnt=0.
    - Otherwise stay in RDY; idle cycles are seen with tcb_rdy=1.
  - Result: first tcb_rdy=1 in the first cycle after reset release with BPR==0; exactly BPR stall cycles per transfer otherwise.
- Address decode:
  - Word index = tcb_adr[AW-1:2].
  - Error if tcb_adr[1:0]!=0 or word index >= SIZE.
- Transfer (on trn):
  - Write, no error: mem[idx] updated per byte lane i where tcb_ben[i]=1; other lanes unchanged. Response rdt=0, err=0.
  - Write, error: memory untouched; response rdt=0, err=1.
  - Read, no error: rdt = mem[idx] sampled in the trn cycle. A write to the same word in an earlier cycle is visible; no same-cycle hazard, since one transfer per cycle.
  - Read, error: rdt=0, err=1.
- Response pipeline:
  - DLY stages of {vld, rdt, err}.
  - Stage DLY drives tcb_rdt/tcb_err registered, DLY clock edges after the trn edge.
  - In cycles without a response: tcb_rdt=0, tcb_err=0.
  - Back-to-back transfers produce back-to-back responses in order; no reordering, no stalls.
- Protocol assumption on the manager: request held stable while tcb_vld & ~tcb_rdy. Violations are not detected.
- Elaboration: fatal error if DLY outside 1..4, DW!=32, or SIZE > 2**(AW-2).

Test Plan:
- Reset/ready, BPR=0: release rst, hold tcb_vld=0 -> tcb_rdy=0 during reset, 1 from the first cycle after release; tcb_rdt=0, tcb_err=0 throughout.
- Write/read, DLY=1: write adr=0x04, wdt=0xDEADBEEF, ben=0xF; then read adr=0x04 -> tcb_rdt=0xDEADBEEF, err=0, one cycle after the read trn.
- Byte enables: write 0x11223344 to adr=0x08 with ben=0xF, then wdt=0xAABBCCDD with ben=0x5; read adr=0x08 -> 0x11BB33DD.
- Errors, SIZE=64: read adr=0x102 -> err=1, rdt=0. Write adr=0x100 (idx 64) -> err=1. Subsequent read of 0x100 -> err=1; mem[0] unchanged.
- Backpressure, BPR=2, DLY=3: continuous vld, 3 back-to-back reads -> tcb_rdy pattern 0,0,1 repeating; each response exactly 3 cycles after its trn; monitor reports bpr=2 per transfer.
- Reset mid-operation, DLY=4: assert rst 2 cycles after a read trn -> no response emitted after reset release; tcb_rdy low until the cycle after release.
